// File: rtl/alu_logic_shift_unit.sv
// alu_logic_shift_unit: single-cycle logic ops plus iterative STEP-bits-per-cycle shifts behind valid/ready handshakes.
module alu_logic_shift_unit #(
  parameter int W    = 32,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [W-1:0]         alu_a,
  input  logic [W-1:0]         alu_b,
  input  logic [$clog2(W)-1:0] shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         result,
  output logic                 busy
);
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] step_max = SW'(STEP);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] result_n, logic_res, shifted, sra_res;
  logic [SW-1:0] rem, rem_n, d;
  // low two op bits of the latched shift: 01 SLL, 10 SRL, 11 SRA
  logic [1:0] sop, sop_n;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_comb begin
    d         = rem > step_max ? step_max : rem;
    sra_res   = $signed(result) >>> d;
    shifted   = sop == 2'b01 ? result << d : sop == 2'b10 ? result >> d : sra_res;
    logic_res = op == 3'b000 ? alu_a & alu_b :
                op == 3'b001 ? alu_a | alu_b :
                op == 3'b010 ? alu_a ^ alu_b :
                op == 3'b011 ? ~(alu_a | alu_b) : {alu_b[W/2-1:0], {W/2{1'b0}}};
    state_n   = state;
    result_n  = result;
    rem_n     = rem;
    sop_n     = sop;
    case (state)
      IDLE: if (in_valid) begin
        if (op < 3'd5) begin
          result_n = logic_res;
          state_n  = DONE;
        end else begin
          result_n = alu_b;
          rem_n    = shamt;
          sop_n    = op[1:0];
          state_n  = shamt == '0 ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_n = shifted;
        rem_n    = rem - d;
        state_n  = rem == d ? DONE : SHIFT;
      end
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      rem    <= '0;
      sop    <= '0;
    end else begin
      state  <= state_n;
      result <= result_n;
      rem    <= rem_n;
      sop    <= sop_n;
    end
  end
endmodule

// File: tb/tb_alu_logic_shift_unit.sv
// tb_alu_logic_shift_unit: three configurations (32/1, 32/4, 16/3) checked every cycle against a closed-form model.
module tb_alu_logic_shift_unit;
  localparam int N = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic iv[N], orr[N], ir[N], ov[N], bz[N];
  logic [2:0] op[N];
  logic [31:0] a[N], b[N];
  logic [4:0] sh[N];
  logic [31:0] r0, r1;
  logic [15:0] r2;
  int checks = 0, errors = 0;
  bit cmp_en = 0;
  int ms[N], mk[N], mn[N];
  int acc[N] = '{0, 0, 0};
  logic [31:0] mres[N], mb[N];
  logic [2:0] mop[N];

  alu_logic_shift_unit #(.W(32), .STEP(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .op(op[0]), .alu_a(a[0]), .alu_b(b[0]), .shamt(sh[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .result(r0), .busy(bz[0]));
  alu_logic_shift_unit #(.W(32), .STEP(4)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .op(op[1]), .alu_a(a[1]), .alu_b(b[1]), .shamt(sh[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .result(r1), .busy(bz[1]));
  alu_logic_shift_unit #(.W(16), .STEP(3)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .op(op[2]), .alu_a(a[2][15:0]), .alu_b(b[2][15:0]), .shamt(sh[2][3:0]), .out_valid(ov[2]),
    .out_ready(orr[2]), .result(r2), .busy(bz[2]));

  function automatic int wof(int i); return i == 2 ? 16 : 32; endfunction
  function automatic int stepof(int i); return i == 0 ? 1 : (i == 1 ? 4 : 3); endfunction
  function automatic logic [31:0] maskof(int i); return i == 2 ? 32'h0000FFFF : 32'hFFFFFFFF; endfunction
  function automatic logic [31:0] rres(int i); return i == 0 ? r0 : (i == 1 ? r1 : {16'h0, r2}); endfunction
  function automatic int kof(int i, logic [4:0] k); return i == 2 ? int'(k[3:0]) : int'(k); endfunction

  function automatic logic [31:0] ref_logic(int i, logic [2:0] o, logic [31:0] x, logic [31:0] y);
    logic [31:0] m;
    m = maskof(i);
    x = x & m;
    y = y & m;
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x | y) & m;
      default: return (y << (wof(i) / 2)) & m;
    endcase
  endfunction

  // full shift of the original operand by d bits, as the iterative unit must reach after d bits of progress
  function automatic logic [31:0] ref_shift(int i, logic [2:0] o, logic [31:0] y, int d);
    logic [31:0] m;
    m = maskof(i);
    y = y & m;
    if (o == 3'd5) return (y << d) & m;
    if (o == 3'd6) return y >> d;
    return (y >> d) | (y[wof(i)-1] ? (m & ~(m >> d)) : 32'h0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ms[i] <= 0; mres[i] <= '0; mb[i] <= '0; mk[i] <= 0; mn[i] <= 0; mop[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ms[i] == 0 && iv[i]) begin
          acc[i] <= acc[i] + 1;
          if (op[i] < 3'd5) begin
            mres[i] <= ref_logic(i, op[i], a[i], b[i]);
            ms[i] <= 2;
          end else begin
            mres[i] <= b[i] & maskof(i);
            mb[i] <= b[i] & maskof(i);
            mop[i] <= op[i];
            mk[i] <= kof(i, sh[i]);
            mn[i] <= 0;
            ms[i] <= kof(i, sh[i]) == 0 ? 2 : 1;
          end
        end else if (ms[i] == 1) begin
          mn[i] <= mn[i] + 1;
          mres[i] <= ref_shift(i, mop[i], mb[i],
                               (mn[i] + 1) * stepof(i) < mk[i] ? (mn[i] + 1) * stepof(i) : mk[i]);
          if ((mn[i] + 1) * stepof(i) >= mk[i]) ms[i] <= 2;
        end else if (ms[i] == 2 && orr[i]) begin
          ms[i] <= 0;
        end
      end
    end
  end

  task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h at %0t", nm, i, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        check("in_ready", i, 32'(ir[i]), 32'(ms[i] == 0));
        check("out_valid", i, 32'(ov[i]), 32'(ms[i] == 2));
        check("busy", i, 32'(bz[i]), 32'(ms[i] != 0));
        check("result", i, rres(i), mres[i]);
      end
    end
  end

  task automatic run(int i, logic [2:0] o, logic [31:0] x, logic [31:0] y, logic [4:0] k,
                     logic [31:0] expv, int explat);
    int lat, t;
    t = 0;
    @(negedge clk);
    while (!ir[i] && t < 200) begin @(negedge clk); t++; end
    op[i] = o; a[i] = x; b[i] = y; sh[i] = k; iv[i] = 1; orr[i] = 1;
    @(posedge clk);
    #1 iv[i] = 0;
    lat = 1;
    while (!ov[i] && lat < 200) begin
      check("busy_hold", i, {30'h0, bz[i], ir[i]}, 32'h2);
      @(posedge clk);
      #1 lat++;
    end
    check("latency", i, lat, explat);
    check("value", i, rres(i), expv);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      iv[i] = 0; orr[i] = 1; op[i] = '0; a[i] = '0; b[i] = '0; sh[i] = '0;
    end
    #1;
    check("rst_result", 0, r0, 32'h0);
    check("rst_ready", 2, {30'h0, ir[2], ov[2]}, 32'h2);
    check("rst_busy", 0, 32'(bz[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    cmp_en = 1;
    // logic ops, one edge each
    run(0, 3'd0, 32'h80000010, 32'h81000000, 5'd0, 32'h80000000, 1);
    run(0, 3'd1, 32'h80000010, 32'h81000000, 5'd0, 32'h81000010, 1);
    run(0, 3'd2, 32'h80000010, 32'h81000000, 5'd0, 32'h01000010, 1);
    run(0, 3'd3, 32'h80000010, 32'h81000000, 5'd0, 32'h7EFFFFEF, 1);
    // shifts: step 1, step 4, step 3 on 16 bits
    run(0, 3'd7, 32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 32);
    run(1, 3'd5, 32'h0, 32'h00000001, 5'd5, 32'h00000020, 3);
    run(1, 3'd6, 32'h0, 32'hF0000000, 5'd0, 32'hF0000000, 1);
    run(2, 3'd7, 32'h0, 32'h00008001, 5'd15, 32'h0000FFFF, 6);
    run(2, 3'd4, 32'h0, 32'h000000AB, 5'd0, 32'h0000AB00, 1);
    // backpressure: held request must wait until the result handshake completes
    @(negedge clk);
    op[0] = 3'd4; b[0] = 32'h00001234; orr[0] = 0; iv[0] = 1;
    @(posedge clk);
    #1 op[0] = 3'd0; a[0] = 32'hFFFF0000; b[0] = 32'h0F0F0F0F;
    check("bp_first", 0, {ov[0], r0[30:0]}, {1'b1, 31'h12340000});
    repeat (3) begin
      @(posedge clk);
      #1 check("bp_hold", 0, r0, 32'h12340000);
      check("bp_flags", 0, {30'h0, ov[0], ir[0]}, 32'h2);
    end
    orr[0] = 1;
    @(posedge clk);
    #1 check("bp_release", 0, {30'h0, ov[0], ir[0]}, 32'h1);
    @(posedge clk);
    #1 check("bp_next", 0, r0, 32'h0F0F0000);
    check("bp_next_v", 0, 32'(ov[0]), 32'h1);
    iv[0] = 0;
    // asynchronous reset in the middle of a shift
    @(negedge clk);
    op[0] = 3'd5; b[0] = 32'h00000001; sh[0] = 5'd20; iv[0] = 1;
    @(posedge clk);
    #1 iv[0] = 0;
    repeat (7) @(posedge clk);
    #2 rst_n = 0;
    #1 check("arst_result", 0, r0, 32'h0);
    check("arst_flags", 0, {29'h0, ov[0], ir[0], bz[0]}, 32'h2);
    @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    check("arst_after", 0, {ov[0], r0[30:0]}, 32'h0);
    // randomized traffic on all three configurations
    begin
      int base[N];
      int cyc;
      for (int i = 0; i < N; i++) base[i] = acc[i];
      cyc = 0;
      while ((acc[0] - base[0] < 1000 || acc[1] - base[1] < 1000 || acc[2] - base[2] < 1000) && cyc < 40000) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          iv[i] = ($urandom % 3) != 0;
          op[i] = 3'($urandom);
          a[i] = $urandom;
          b[i] = $urandom;
          sh[i] = i == 2 ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
          orr[i] = ($urandom % 4) != 0;
        end
        cyc++;
      end
      check("vectors", 0, 32'(cyc < 40000), 32'h1);
    end
    for (int i = 0; i < N; i++) begin iv[i] = 0; orr[i] = 1; end
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
